// File: rtl/mp_drive_issuer.sv
// mp_drive_issuer
// Clocked front-end for the last micropipeline FIFO stage. Words arrive from
// the synchronous domain, are buffered in a small FIFO, and are launched one at
// a time. Each launch is a DRIVE_W-cycle pulse on o_drive. The next word is not
// launched until the downstream stage returns a free pulse on i_free.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   i_valid/o_ready/i_data  upstream push interface
//   o_drive       drive pulse to the downstream stage
//   i_free        asynchronous free pulse from the downstream stage
//   o_data        word of the current (or last) token, held for its lifetime
//   o_busy        a token is outstanding
//   o_timeout     sticky: no free arrived within TIMEOUT cycles (terminal)
//   o_proto_err   sticky: free edge seen while no token was waiting for it
//   o_tokens      completed-token count, wraps at 16 bits
//   o_dbg_state   current FSM state for observation
//
// Handshake: a word transfers on every rising clk edge where i_valid && o_ready.
// o_ready is combinational from rst, FIFO fullness and the ERR state only. It
// never depends on i_valid. i_data must be stable while i_valid is high.
module mp_drive_issuer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int DRIVE_W     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_drive,
  input  logic              i_free,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_proto_err,
  output logic [15:0]       o_tokens,
  output logic [1:0]        o_dbg_state
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PULSE_W = (DRIVE_W > 1) ? $clog2(DRIVE_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRIVE     = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_ERR       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 drive_q, drive_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 timeout_q, timeout_d;
  logic                 proto_err_q, proto_err_d;
  logic [15:0]          tokens_q, tokens_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [15:0]          timer_q, timer_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 free_prev_q, free_prev_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic full, empty, ready, push, pop, free_edge;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign ready     = !rst && !full && (state_q != ST_ERR);
  assign push      = i_valid && ready;
  // Rising edge of the synchronised free level; one-cycle pulse.
  assign free_edge = sync_q[SYNC_STAGES-1] && !free_prev_q;

  always_comb begin
    state_d     = state_q;
    drive_d     = drive_q;
    data_d      = data_q;
    pulse_d     = pulse_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
    tokens_d    = tokens_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (free_edge) proto_err_d = 1'b1;
        if (!empty) begin
          state_d = ST_DRIVE;
          drive_d = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          pulse_d = PULSE_W'(DRIVE_W - 1);
          pop     = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (free_edge) proto_err_d = 1'b1;
        // pulse counts down the remaining drive cycles; zero means this is the last.
        if (pulse_q == '0) begin
          state_d = ST_WAIT_FREE;
          drive_d = 1'b0;
          timer_d = '0;
        end else begin
          pulse_d = pulse_q - PULSE_W'(1);
        end
      end
      ST_WAIT_FREE: begin
        // A free edge wins over an expiring timer in the same cycle.
        if (free_edge) begin
          state_d  = ST_IDLE;
          tokens_d = tokens_q + 16'd1;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_ERR: begin
        // Terminal until reset; free edges are ignored here.
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT_FREE);
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    sync_d      = {sync_q[SYNC_STAGES-2:0], i_free};
    free_prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      tokens_q    <= '0;
      pulse_q     <= '0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sync_q      <= '0;
      free_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      tokens_q    <= tokens_d;
      pulse_q     <= pulse_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sync_q      <= sync_d;
      free_prev_q <= free_prev_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_ready     = ready;
  assign o_drive     = drive_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;
  assign o_proto_err = proto_err_q;
  assign o_tokens    = tokens_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mp_drive_issuer.sv
// Testbench for mp_drive_issuer with default parameters.
// A queue-based model tracks FIFO contents and the token lifetime as an age in
// cycles since launch. The model is compared against the DUT after every clock
// edge. The directed scenarios also check hand-computed literal values.
module tb_mp_drive_issuer;
  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int DRIVE_W     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_free = 1'b0;
  logic              o_ready, o_drive, o_busy, o_timeout, o_proto_err;
  logic [DATA_W-1:0] o_data;
  logic [15:0]       o_tokens;
  logic [1:0]        o_dbg_state;

  always #5 clk = ~clk;

  mp_drive_issuer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DRIVE_W(DRIVE_W),
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_drive(o_drive), .i_free(i_free), .o_data(o_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_proto_err(o_proto_err),
    .o_tokens(o_tokens), .o_dbg_state(o_dbg_state)
  );

  // ---------------- model ----------------
  logic [DATA_W-1:0] exp_q[$];
  bit                m_in_flight = 0;
  bit                m_dead = 0;
  bit                m_timeout = 0;
  bit                m_proto = 0;
  int                m_age = 0;
  logic [DATA_W-1:0] m_data = '0;
  logic [15:0]       m_tokens = '0;
  bit                hist [SYNC_STAGES+1];
  bit                preload_pulse = 0;

  // hist[k] holds i_free as sampled k+1 edges ago.
  always @(posedge clk) begin : model_b
    bit fe;
    bit can_push;
    if (rst) begin
      exp_q.delete();
      m_in_flight = 0; m_dead = 0; m_timeout = 0; m_proto = 0;
      m_age = 0; m_data = '0; m_tokens = '0;
      for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 0;
    end else begin
      if (preload_pulse) m_tokens = 16'hFFFF;
      fe = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
      can_push = i_valid && (exp_q.size() < DEPTH) && !m_dead;
      if (m_dead) begin
        // terminal
      end else if (!m_in_flight) begin
        if (fe) m_proto = 1;
        if (exp_q.size() > 0) begin
          m_data = exp_q.pop_front();
          m_in_flight = 1;
          m_age = 0;
        end
      end else if (m_age < DRIVE_W) begin
        if (fe) m_proto = 1;
        m_age++;
      end else begin
        if (fe) begin
          m_in_flight = 0;
          m_tokens = m_tokens + 16'd1;
        end else if (m_age - DRIVE_W == TIMEOUT - 1) begin
          m_dead = 1; m_timeout = 1; m_in_flight = 0;
        end else begin
          m_age++;
        end
      end
      if (can_push) exp_q.push_back(i_data);
      for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = i_free;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_drive",   32'(o_drive),     32'(m_in_flight && (m_age < DRIVE_W)));
    chk("m_busy",    32'(o_busy),      32'(m_in_flight));
    chk("m_ready",   32'(o_ready),     32'(!rst && (exp_q.size() < DEPTH) && !m_dead));
    chk("m_data",    32'(o_data),      32'(m_data));
    chk("m_timeout", 32'(o_timeout),   32'(m_timeout));
    chk("m_proto",   32'(o_proto_err), 32'(m_proto));
    chk("m_tokens",  32'(o_tokens),    32'(m_tokens));
  endtask

  // One clock: compare just after the edge, return at the following negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  // Wait for the token to reach its free window, confirm its word, return one
  // free pulse, then wait for the completion.
  task automatic free_token(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    while (!(o_busy && !o_drive) && n < 50) begin cyc(); n++; end
    chk("free_window_reached", 32'(n < 50), 32'd1);
    chk("token_word", 32'(o_data), 32'(w));
    i_free = 1'b1;
    cyc();
    i_free = 1'b0;
    n = 0;
    while (o_busy && n < 20) begin cyc(); n++; end
    chk("token_completed", 32'(n < 20), 32'd1);
  endtask

  logic [DATA_W-1:0] words [5];

  initial begin
    int n;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55;

    // ---- reset state ----
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_drive",  32'(o_drive), 32'd0);
    chk("rst_busy",   32'(o_busy), 32'd0);
    chk("rst_ready",  32'(o_ready), 32'd0);
    chk("rst_tokens", 32'(o_tokens), 32'd0);
    chk("rst_data",   32'(o_data), 32'd0);

    // ---- single token, hand-timed ----
    rst = 1'b0; i_valid = 1'b1; i_data = 8'hA5;
    cyc();                                  // edge 0: push
    i_valid = 1'b0;
    cyc();                                  // edge 1: launch
    chk("t1_drive_e1", 32'(o_drive), 32'd1);
    chk("t1_data_e1",  32'(o_data), 32'hA5);
    chk("t1_busy_e1",  32'(o_busy), 32'd1);
    cyc();
    chk("t1_drive_e2", 32'(o_drive), 32'd1);
    cyc();
    chk("t1_drive_e3", 32'(o_drive), 32'd0);
    chk("t1_busy_e3",  32'(o_busy), 32'd1);
    cyc(); cyc();
    i_free = 1'b1;
    cyc();                                  // edge 6 samples free
    i_free = 1'b0;
    cyc();
    chk("t1_busy_e7",  32'(o_busy), 32'd1);
    cyc();
    chk("t1_busy_e8",   32'(o_busy), 32'd0);
    chk("t1_tokens_e8", 32'(o_tokens), 32'd1);
    chk("t1_proto",     32'(o_proto_err), 32'd0);

    // ---- five back-to-back words, FIFO fills ----
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_data = words[k];
      cyc();
    end
    i_valid = 1'b0;
    chk("t2_full_ready", 32'(o_ready), 32'd0);
    for (int k = 0; k < 5; k++) free_token(words[k]);
    repeat (3) cyc();
    chk("t2_tokens", 32'(o_tokens), 32'd6);
    chk("t2_idle",   32'(o_busy), 32'd0);
    chk("t2_ready",  32'(o_ready), 32'd1);

    // ---- timeout ----
    i_valid = 1'b1; i_data = 8'h3C;
    cyc();
    i_valid = 1'b0;
    n = 0;
    while (!(o_busy && !o_drive) && n < 50) begin cyc(); n++; end
    chk("t3_wait_reached", 32'(n < 50), 32'd1);
    repeat (TIMEOUT - 1) cyc();
    chk("t3_not_yet", 32'(o_timeout), 32'd0);
    cyc();
    chk("t3_timeout", 32'(o_timeout), 32'd1);
    chk("t3_ready",   32'(o_ready), 32'd0);
    chk("t3_busy",    32'(o_busy), 32'd0);
    i_valid = 1'b1; i_data = 8'h77;
    cyc(); cyc();
    i_valid = 1'b0;
    i_free = 1'b1;
    cyc();
    i_free = 1'b0;
    repeat (4) cyc();
    chk("t3_tokens_held", 32'(o_tokens), 32'd6);
    chk("t3_proto_held",  32'(o_proto_err), 32'd0);
    chk("t3_drive_none",  32'(o_drive), 32'd0);

    // ---- stray free in IDLE ----
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_timeout_clr", 32'(o_timeout), 32'd0);
    i_free = 1'b1;
    cyc();
    i_free = 1'b0;
    repeat (3) cyc();
    chk("t4_proto",  32'(o_proto_err), 32'd1);
    chk("t4_idle",   32'(o_dbg_state), 32'd0);
    chk("t4_busy",   32'(o_busy), 32'd0);
    chk("t4_tokens", 32'(o_tokens), 32'd0);
    i_valid = 1'b1; i_data = 8'h5A;
    cyc();
    i_valid = 1'b0;
    free_token(8'h5A);
    chk("t4_tokens_after", 32'(o_tokens), 32'd1);
    chk("t4_proto_sticky", 32'(o_proto_err), 32'd1);

    // ---- reset in the middle of DRIVE with two words buffered ----
    i_valid = 1'b1; i_data = 8'h11; cyc();
    i_data = 8'h22; cyc();
    i_data = 8'h33; cyc();
    i_valid = 1'b0;
    chk("t5_mid_drive", 32'(o_drive), 32'd1);
    rst = 1'b1;
    cyc();
    chk("t5_drive_off", 32'(o_drive), 32'd0);
    chk("t5_busy",      32'(o_busy), 32'd0);
    chk("t5_tokens",    32'(o_tokens), 32'd0);
    chk("t5_ready_rst", 32'(o_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", 32'(o_ready), 32'd1);
    repeat (3) cyc();
    chk("t5_no_drive", 32'(o_drive), 32'd0);
    chk("t5_empty",    32'(o_busy), 32'd0);

    // ---- counter wrap: counter preloaded to 0xFFFF to keep the run short ----
    force dut.tokens_q = 16'hFFFF;
    preload_pulse = 1'b1;
    cyc();
    release dut.tokens_q;
    preload_pulse = 1'b0;
    cyc();
    chk("t6_preload", 32'(o_tokens), 32'hFFFF);
    i_valid = 1'b1; i_data = 8'h99;
    cyc();
    i_valid = 1'b0;
    free_token(8'h99);
    chk("t6_wrap", 32'(o_tokens), 32'h0000);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
